// File: rtl/resistor_capacitor_low_pass_filter_cascade.sv
// Time-multiplexed cascade of first-order RC low-pass sections sharing one multiplier.
// Each accepted sample walks through every stage; the final stage output is published with a one-cycle out_valid.
module resistor_capacitor_low_pass_filter_cascade #(
  parameter int SAMPLE_RATE    = 48000,
  parameter int R              = 47000,
  parameter int C_35_SHIFTED   = 1615,
  parameter int STAGES         = 2,
  parameter int ALPHA_OVERRIDE = 0
) (
  input  logic               clk,
  input  logic               I_RST,
  input  logic               audio_clk_en,
  input  logic signed [15:0] in,
  output logic signed [15:0] out,
  output logic               out_valid,
  output logic               busy,
  output logic               overrun,
  output logic [1:0]         dbg_state_o
);

  localparam logic [63:0] DT32       = (64'd1 << 32) / 64'(SAMPLE_RATE);
  localparam logic [63:0] RC32       = (64'(R) * 64'(C_35_SHIFTED)) >> 3;
  localparam logic [63:0] ALPHA_CALC = (DT32 << 16) / (RC32 + DT32);
  localparam logic [15:0] ALPHA      = (ALPHA_OVERRIDE != 0) ? 16'(ALPHA_OVERRIDE) : ALPHA_CALC[15:0];
  localparam int          KW         = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam logic [KW-1:0] LAST     = KW'(STAGES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, UPD = 2'd2, DONE = 2'd3} state_t;

  state_t             state_q;
  logic [KW-1:0]      k_q;
  logic signed [15:0] x_q;
  logic signed [15:0] y_q [STAGES];
  logic signed [33:0] prod_q;
  logic signed [15:0] out_q;
  logic               out_valid_q;
  logic               busy_q;
  logic               overrun_q;

  logic signed [15:0] y_cur;
  logic signed [16:0] diff;
  logic signed [33:0] prod_d;
  logic signed [17:0] sum;
  logic signed [15:0] y_d;

  // Handshake: audio_clk_en is a single-cycle strobe accepted only in IDLE;
  // out_valid is a single-cycle pulse, and out holds its value between pulses.
  always_comb begin
    y_cur  = y_q[k_q];
    diff   = {x_q[15], x_q} - {y_cur[15], y_cur};
    prod_d = $signed({1'b0, ALPHA}) * diff;
    sum    = {{2{y_cur[15]}}, y_cur} + prod_q[33:16];
    y_d    = sum[15:0];
    if (sum > 18'sd32767) begin
      y_d = 16'sh7fff;
    end else if (sum < -18'sd32768) begin
      y_d = -16'sh8000;
    end
  end

  always_ff @(posedge clk or posedge I_RST) begin
    if (I_RST) begin
      state_q     <= IDLE;
      k_q         <= '0;
      x_q         <= '0;
      prod_q      <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      for (int s = 0; s < STAGES; s++) begin
        y_q[s] <= '0;
      end
    end else begin
      out_valid_q <= 1'b0;
      if (audio_clk_en && (state_q != IDLE)) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (audio_clk_en) begin
            x_q     <= in;
            k_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= MUL;
          end
        end
        MUL: begin
          prod_q  <= prod_d;
          state_q <= UPD;
        end
        UPD: begin
          y_q[k_q] <= y_d;
          x_q      <= y_d;
          if (k_q == LAST) begin
            state_q <= DONE;
          end else begin
            k_q     <= k_q + 1'b1;
            state_q <= MUL;
          end
        end
        DONE: begin
          out_q       <= y_q[STAGES-1];
          out_valid_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out         = out_q;
  assign out_valid   = out_valid_q;
  assign busy        = busy_q;
  assign overrun     = overrun_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_resistor_capacitor_low_pass_filter_cascade.sv
// Bench for the RC low-pass cascade: five instances with different stage counts and alphas,
// checked every cycle against a behavioural cascade model plus a few literal results.
module tb_resistor_capacitor_low_pass_filter_cascade;

  localparam int N = 5;

  function automatic int stg_of(int g);
    case (g)
      0:       return 1;
      1, 2, 3: return 2;
      default: return 3;
    endcase
  endfunction

  function automatic int ovr_of(int g);
    case (g)
      1:       return 32768;
      2:       return 65535;
      4:       return 32768;
      default: return 0;
    endcase
  endfunction

  // ---------------- clock / reset / DUTs ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst  [N];
  logic        stb  [N];
  logic [15:0] din  [N];
  logic [15:0] dout [N];
  logic        vld  [N];
  logic        bsy  [N];
  logic        ovf  [N];
  logic [1:0]  dst  [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    resistor_capacitor_low_pass_filter_cascade #(
      .STAGES(stg_of(g)),
      .ALPHA_OVERRIDE(ovr_of(g))
    ) u_dut (
      .clk(clk),
      .I_RST(rst[g]),
      .audio_clk_en(stb[g]),
      .in(din[g]),
      .out(dout[g]),
      .out_valid(vld[g]),
      .busy(bsy[g]),
      .overrun(ovf[g]),
      .dbg_state_o(dst[g])
    );
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural model ----------------
  int          my     [N][8];
  int          free_e [N];
  int          acc_e  [N];
  int          ov_e   [N];
  int          last_e [N];
  logic [15:0] held   [N];
  logic [15:0] exp_q  [N][$];
  int          expc_q [N][$];
  int          n_checks = 0;
  int          n_pass   = 0;

  function automatic longint alpha_of(int g);
    longint dt, rc;
    if (ovr_of(g) != 0) return longint'(ovr_of(g));
    dt = (longint'(1) << 32) / 48000;
    rc = (longint'(47000) * 1615) / 8;
    return (dt * 65536) / (rc + dt);
  endfunction

  function automatic longint floor_div(longint p);
    if (p >= 0) return p / 65536;
    return -((-p + 65535) / 65536);
  endfunction

  function automatic int sat16(longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  task automatic model_clear(int g);
    for (int s = 0; s < 8; s++) my[g][s] = 0;
    exp_q[g].delete();
    expc_q[g].delete();
    held[g]   = '0;
    acc_e[g]  = -100;
    ov_e[g]   = 1 << 30;
    free_e[g] = 0;
  endtask

  task automatic check(string name, int g, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s dut%0d cyc=%0d: got %0d, expected %0d", name, g, cyc, act, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset(int g, int cycles);
    @(posedge clk); #2;
    rst[g] = 1'b1;
    model_clear(g);
    repeat (cycles) @(posedge clk);
    #2 rst[g] = 1'b0;
  endtask

  task automatic strobe(int g, int val);
    int e;
    longint x;
    @(posedge clk); #2;
    e      = cyc + 1;
    stb[g] = 1'b1;
    din[g] = 16'(val);
    if (e >= free_e[g]) begin
      x = val;
      for (int s = 0; s < stg_of(g); s++) begin
        my[g][s] = sat16(my[g][s] + floor_div(alpha_of(g) * (x - my[g][s])));
        x = my[g][s];
      end
      exp_q[g].push_back(16'(x));
      expc_q[g].push_back(e + 2 * stg_of(g) + 1);
      acc_e[g]  = e;
      last_e[g] = e;
      free_e[g] = e + 2 * stg_of(g) + 2;
    end else if (ov_e[g] > e) begin
      ov_e[g] = e;
    end
    @(posedge clk); #2;
    stb[g] = 1'b0;
  endtask

  task automatic expect_lit(int g, int lit);
    int target;
    target = last_e[g] + 2 * stg_of(g) + 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cyc == target) break;
    end
    check("lit_cycle", g, cyc, target);
    check("lit_valid", g, int'(vld[g]), 1);
    check("lit_out", g, int'($signed(dout[g])), lit);
  endtask

  task automatic random_run(int g, int count, bit extremes);
    int v;
    for (int i = 0; i < count; i++) begin
      case ($urandom_range(0, 3))
        0:       v = extremes ? 32767 : int'($urandom_range(0, 32767));
        1:       v = extremes ? -32768 : -int'($urandom_range(0, 32768));
        default: v = int'($urandom_range(0, 65535)) - 32768;
      endcase
      strobe(g, v);
      repeat ($urandom_range(0, 6)) @(posedge clk);
    end
    repeat (2 * stg_of(g) + 4) @(posedge clk);
  endtask

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    bit exp_v;
    if (cyc >= 1) begin
      for (int g = 0; g < N; g++) begin
        while (expc_q[g].size() > 0 && expc_q[g][0] < cyc) begin
          void'(exp_q[g].pop_front());
          void'(expc_q[g].pop_front());
        end
        exp_v = (expc_q[g].size() > 0) && (expc_q[g][0] == cyc);
        check("out_valid", g, int'(vld[g]), int'(exp_v));
        if (exp_v) begin
          held[g] = exp_q[g].pop_front();
          void'(expc_q[g].pop_front());
        end
        check("out", g, int'($signed(dout[g])), int'($signed(held[g])));
        check("busy", g, int'(bsy[g]), int'(cyc >= acc_e[g] && cyc <= acc_e[g] + 2 * stg_of(g)));
        check("overrun", g, int'(ovf[g]), int'(cyc >= ov_e[g]));
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    for (int g = 0; g < N; g++) begin
      rst[g] = 1'b1;
      stb[g] = 1'b0;
      din[g] = '0;
      last_e[g] = 0;
      model_clear(g);
    end
    repeat (3) @(posedge clk);
    #2;
    for (int g = 0; g < N; g++) rst[g] = 1'b0;

    // Single stage, derived alpha: step response and floor on negative input.
    strobe(0, 10000); expect_lit(0, 93);
    strobe(0, 10000); expect_lit(0, 185);
    strobe(0, 10000); expect_lit(0, 276);
    do_reset(0, 2);
    strobe(0, -10000); expect_lit(0, -94);
    random_run(0, 20, 1'b0);

    // Two stages, alpha = 1/2.
    strobe(1, 1000); expect_lit(1, 250);
    strobe(1, 1000); expect_lit(1, 500);
    random_run(1, 20, 1'b0);

    // Two stages, alpha near one, full-scale swings.
    strobe(2, 32767);  expect_lit(2, 32765);
    strobe(2, -32768); expect_lit(2, -32768);
    random_run(2, 30, 1'b1);

    // Strobe two cycles into processing is dropped and overrun sticks.
    strobe(3, 5000);
    strobe(3, -7000);
    expect_lit(3, 0);
    check("overrun_sticky", 3, int'(ovf[3]), 1);
    random_run(3, 30, 1'b0);

    // Three stages: reset in the fourth processing cycle, then a clean sample.
    strobe(4, 20000);
    repeat (2) @(posedge clk);
    do_reset(4, 1);
    check("rst_busy", 4, int'(bsy[4]), 0);
    check("rst_out", 4, int'($signed(dout[4])), 0);
    strobe(4, 1000); expect_lit(4, 125);
    random_run(4, 15, 1'b0);

    repeat (10) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/resistor_capacitor_low_pass_filter_cascade.md
Name: resistor_capacitor_low_pass_filter_cascade

Overview:
- Time-multiplexed cascade of STAGES identical first-order RC low-pass sections.
- All sections share one multiplier.
- It is the low-pass counterpart to the team's RC high-pass filter. It sits in the same discrete-audio chain, on the same audio_clk_en sample strobe.
- Each accepted sample is run through every stage in order. The result is presented on out with a one-cycle out_valid pulse.

Parameters:
- SAMPLE_RATE, 48000: sample strobe rate in Hz; sets delta-t.
- R, 47000: section resistance in ohms.
- C_35_SHIFTED, 1615: section capacitance in farads, scaled by 2^35.
- STAGES, 2: number of cascaded sections, 1..8.
- ALPHA_OVERRIDE, 0: if nonzero, used directly as the 16-bit alpha; if 0, alpha is derived from R/C.

Ports:
- clk, input, 1: system clock.
- I_RST, input, 1: asynchronous, active-high reset.
- audio_clk_en, input, 1: sample strobe, one clk wide.
- in, input, 16: signed audio sample.
- out, output, 16: signed filtered sample; holds between updates.
- out_valid, output, 1: one-cycle pulse when out updates.
- busy, output, 1: high while a sample is being processed.
- overrun, output, 1: sticky; set when a strobe arrives while busy.

Behaviour:
- One clock domain. Reset is asynchronous and active-high on I_RST; the clock is clk.
- Reset value of every output and every piece of state is 0: out, out_valid, busy, overrun, all stage states, stage index and FSM (IDLE).
- Alpha constants, all computed as 64-bit values at elaboration:
  - DT32 = 2^32 / SAMPLE_RATE
  - RC32 = (R * C_35_SHIFTED) >> 3
  - ALPHA = (DT32 << 16) / (RC32 + DT32)
  - For the defaults, ALPHA = 612.
  - ALPHA_OVERRIDE replaces ALPHA when nonzero.
- Stage update: y[k] <= y[k] + ((ALPHA * (x - y[k])) >>> 16).
  - x is the sample for stage 0, else the freshly updated y[k-1].
  - The difference x - y[k] is a 17-bit signed value.
  - The product is 34-bit signed.
  - The shift is arithmetic, so it rounds toward minus infinity.
  - The sum is formed at 18 bits, then saturated to [-32768, 32767].
- FSM:
  - IDLE: on audio_clk_en, latch in into x_reg, set k=0, set busy=1, go to MUL.
  - MUL: register prod = ALPHA * (x - y[k]); go to UPD.
  - UPD: write y[k]; feed it forward as x. If k == STAGES-1, go to DONE; else increment k and go to MUL.
  - DONE: out <= y[STAGES-1]; pulse out_valid for 1 cycle; clear busy; return to IDLE.
- Latency: out_valid asserts 2*STAGES+1 cycles after the clk edge that samples audio_clk_en. For STAGES=2 this is 5 cycles.
- Strobe while busy (MUL/UPD/DONE):
  - The sample is dropped and the in-flight computation is unaffected.
  - overrun is set and stays set until reset.
- Strobe in the same cycle as the DONE-to-IDLE transition counts as busy (dropped). A strobe is accepted only in IDLE.
- out is updated only in DONE; it never shows partial cascade values.
- Reset mid-operation:
  - All states return to 0 immediately.
  - No out_valid is produced for the aborted sample.
  - The next strobe after reset release is processed normally.
- Stage states are retained between samples, which forms the filter memory. No noise injection.

Test Plan:
- STAGES=1, defaults (ALPHA=612); reset, then in=10000 on 3 strobes → out = 93, then 185, then 276, each with out_valid exactly 3 cycles after the strobe.
- STAGES=1; in=-10000 single strobe from reset → out = -94, which checks arithmetic flooring.
- STAGES=2, ALPHA_OVERRIDE=32768; in=1000 held for 2 strobes → stage 0 goes 500 then 750; out = 250 then 500; latency 5 cycles.
- STAGES=2, ALPHA_OVERRIDE=65535; in=32767 then -32768 → out stays within range; no wrap. Check every out against a saturating reference model.
- STAGES=2; second strobe 2 cycles after the first → second sample ignored, overrun=1 and sticky, single out_valid with the first sample's result.
- STAGES=3; assert I_RST during the 4th cycle of processing → out=0, busy=0, no out_valid. Next strobe with in=1000, ALPHA_OVERRIDE=32768 → out=125.
